// File: rtl/fetch_controller.sv
// Instruction fetch controller: sequences IF-stage requests, PC/IF-ID enables,
// redirects (branch/jump), load-use stalls and a fetch timeout watchdog.
module fetch_controller #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             jump_or_i,
   input  logic             br_and_i,
   input  logic             stall_in_i,
   input  logic             mem_ack_i,
   output logic             mem_req_o,
   output logic             pc_write_o,
   output logic [1:0]       pc_sel_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             redirect_pending_o,
   output logic [CNT_W-1:0] fetch_count_o,
   output logic             timeout_err_o
);

   // Wide enough to hold MAX_WAIT; MAX_WAIT must be at least 1.
   localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

   localparam logic [1:0] SelSeq = 2'b00;
   localparam logic [1:0] SelBr  = 2'b01;
   localparam logic [1:0] SelJmp = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StHold,
      StRedirect,
      StError
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               pending_q;
   logic               terr_q;

   logic               redirect;
   logic [1:0]         in_sel;

   // Jump wins over branch, so the select can never be 2'b11.
   assign redirect = jump_or_i | br_and_i;
   assign in_sel   = jump_or_i ? SelJmp : SelBr;

   // Next-state logic and combinational control outputs.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      wait_d       = wait_q;
      count_d      = count_q;
      mem_req_o    = 1'b0;
      pc_write_o   = 1'b0;
      pc_sel_o     = SelSeq;
      ifid_write_o = 1'b0;
      ifid_flush_o = 1'b0;

      unique case (state_q)
         StIdle: begin
            state_d = StFetch;
            wait_d  = '0;
         end

         StFetch: begin
            mem_req_o = 1'b1;
            if (redirect) begin
               wait_d = '0;
               if (mem_ack_i) begin
                  // Redirect resolved immediately; the fetched word is squashed.
                  pc_write_o   = 1'b1;
                  pc_sel_o     = in_sel;
                  ifid_flush_o = 1'b1;
               end else begin
                  sel_d   = in_sel;
                  state_d = StRedirect;
               end
            end else if (stall_in_i) begin
               wait_d  = '0;
               state_d = StHold;
            end else if (mem_ack_i) begin
               pc_write_o   = 1'b1;
               ifid_write_o = 1'b1;
               count_d      = count_q + CNT_W'(1);
               wait_d       = '0;
            end else if (wait_q == WaitLast) begin
               state_d = StError;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end

         StHold: begin
            if (redirect) begin
               sel_d   = in_sel;
               wait_d  = '0;
               state_d = StRedirect;
            end else if (!stall_in_i) begin
               // Same PC is refetched since pc_write stayed low.
               wait_d  = '0;
               state_d = StFetch;
            end
         end

         StRedirect: begin
            mem_req_o = 1'b1;
            if (mem_ack_i) begin
               pc_write_o   = 1'b1;
               pc_sel_o     = sel_q;
               ifid_flush_o = 1'b1;
               wait_d       = '0;
               state_d      = StFetch;
            end else begin
               // Newest redirect overwrites the latched target select.
               if (redirect) begin
                  sel_d = in_sel;
               end
               if (wait_q == WaitLast) begin
                  state_d = StError;
               end else begin
                  wait_d = wait_q + WaitW'(1);
               end
            end
         end

         StError: begin
            state_d = StError;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and registered outputs; reset drops any latched redirect.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         sel_q     <= SelSeq;
         wait_q    <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         wait_q    <= wait_d;
         count_q   <= count_d;
         pending_q <= (state_d == StRedirect);
         terr_q    <= (state_d == StError);
      end
   end

   assign redirect_pending_o = pending_q;
   assign fetch_count_o      = count_q;
   assign timeout_err_o      = terr_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: vector table plus reset/timeout/wrap sequences.
module tb_fetch_controller;

   localparam int unsigned CntW = 4;

   logic            clk;
   logic            rst_n;
   logic            jump, br, stall, ack;
   logic            mem_req, pc_write, ifid_write, ifid_flush, pending, terr;
   logic [1:0]      pc_sel;
   logic [CntW-1:0] count;

   int total = 0;
   int bad   = 0;

   fetch_controller #(
      .MAX_WAIT (15),
      .CNT_W    (CntW)
   ) dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .jump_or_i          (jump),
      .br_and_i           (br),
      .stall_in_i         (stall),
      .mem_ack_i          (ack),
      .mem_req_o          (mem_req),
      .pc_write_o         (pc_write),
      .pc_sel_o           (pc_sel),
      .ifid_write_o       (ifid_write),
      .ifid_flush_o       (ifid_flush),
      .redirect_pending_o (pending),
      .fetch_count_o      (count),
      .timeout_err_o      (terr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench did not finish");
   end

   typedef struct packed {
      logic       j, b, s, a;
      logic       mreq, pcw;
      logic [1:0] sel;
      logic       wr, fl, pend;
      logic [3:0] cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic j, logic b, logic s, logic a, logic mreq, logic pcw,
                               logic [1:0] sel, logic wr, logic fl, logic pend,
                               logic [3:0] cnt);
      vec_t v;
      v.j = j; v.b = b; v.s = s; v.a = a;
      v.mreq = mreq; v.pcw = pcw; v.sel = sel; v.wr = wr; v.fl = fl;
      v.pend = pend; v.cnt = cnt;
      tbl.push_back(v);
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic j, logic b, logic s, logic a);
      jump = j; br = b; stall = s; ack = a;
   endtask

   initial begin
      drive(0, 0, 0, 0);
      rst_n = 1'b0;

      // j b s a | mreq pcw sel wr fl pend cnt
      add(0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 4'd0);            // IDLE
      for (int i = 1; i <= 9; i++) begin
         add(0, 0, 0, 1, 1, 1, 2'b00, 1, 0, 0, 4'(i - 1));     // streaming accepts
      end
      add(0, 1, 0, 1, 1, 1, 2'b01, 0, 1, 0, 4'd9);            // branch with ack
      add(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 4'd9);            // waiting
      add(1, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 4'd9);            // jump, no ack
      add(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 4'd9);            // REDIRECT
      add(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 4'd9);
      add(0, 0, 0, 1, 1, 1, 2'b10, 0, 1, 1, 4'd9);            // ack 3 cycles later
      add(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 4'd9);            // back in FETCH
      add(0, 0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 4'd9);            // stall beats accept
      add(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 4'd9);            // HOLD
      add(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 4'd9);
      add(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 4'd9);
      add(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'd9);            // release
      add(0, 0, 0, 1, 1, 1, 2'b00, 1, 0, 0, 4'd9);            // refetch accepted
      add(0, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 4'd10);           // stall -> HOLD
      add(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 4'd10);           // stall+branch
      add(1, 0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 4'd10);           // newer jump overwrites
      add(0, 0, 0, 1, 1, 1, 2'b10, 0, 1, 1, 4'd10);
      add(1, 1, 0, 1, 1, 1, 2'b10, 0, 1, 0, 4'd10);           // both -> jump
      add(0, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0, 4'd10);           // branch, no ack
      add(0, 0, 0, 1, 1, 1, 2'b01, 0, 1, 1, 4'd10);
      add(0, 0, 0, 1, 1, 1, 2'b00, 1, 0, 0, 4'd10);
      add(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 4'd11);

      // Reset state
      tick();
      tick();
      chk("rst mem_req", 32'(mem_req), 0);
      chk("rst pc_write", 32'(pc_write), 0);
      chk("rst pending", 32'(pending), 0);
      chk("rst count", 32'(count), 0);
      chk("rst terr", 32'(terr), 0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].j, tbl[i].b, tbl[i].s, tbl[i].a);
         #2;
         chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(tbl[i].mreq));
         chk($sformatf("v%0d pc_write", i), 32'(pc_write), 32'(tbl[i].pcw));
         chk($sformatf("v%0d pc_sel", i), 32'(pc_sel), 32'(tbl[i].sel));
         chk($sformatf("v%0d ifid_write", i), 32'(ifid_write), 32'(tbl[i].wr));
         chk($sformatf("v%0d ifid_flush", i), 32'(ifid_flush), 32'(tbl[i].fl));
         chk($sformatf("v%0d pending", i), 32'(pending), 32'(tbl[i].pend));
         chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("v%0d terr", i), 32'(terr), 0);
         tick();
      end

      // Counter wrap: 11 + 5 accepts -> 0 in a 4-bit counter
      drive(0, 0, 0, 1);
      repeat (5) tick();
      chk("wrap count", 32'(count), 0);
      tick();
      chk("wrap count+1", 32'(count), 1);

      // Reset while in REDIRECT drops the pending redirect
      drive(1, 0, 0, 0);
      tick();
      chk("redir pending", 32'(pending), 1);
      drive(0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst pending", 32'(pending), 0);
      chk("async rst mem_req", 32'(mem_req), 0);
      chk("async rst count", 32'(count), 0);
      tick();
      rst_n = 1'b1;
      #2;
      chk("post rst idle mem_req", 32'(mem_req), 0);
      tick();
      #2;
      chk("post rst fetch mem_req", 32'(mem_req), 1);
      chk("post rst pending", 32'(pending), 0);

      // Timeout: this is FETCH wait cycle 1; 14 more reach the limit
      repeat (14) tick();
      chk("pre timeout terr", 32'(terr), 0);
      chk("pre timeout mem_req", 32'(mem_req), 1);
      tick();
      chk("timeout terr", 32'(terr), 1);
      chk("timeout mem_req", 32'(mem_req), 0);
      drive(1, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("err%0d terr", k), 32'(terr), 1);
         chk($sformatf("err%0d mem_req", k), 32'(mem_req), 0);
         chk($sformatf("err%0d pc_write", k), 32'(pc_write), 0);
         chk($sformatf("err%0d ifid_flush", k), 32'(ifid_flush), 0);
         chk($sformatf("err%0d pending", k), 32'(pending), 0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("err rst terr", 32'(terr), 0);
      chk("err rst mem_req", 32'(mem_req), 0);
      drive(0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
